// File: rtl/rx_crc_flag.sv
// Receive-side CRC-32 / length checker on the 12-bit side bus. The bus passes
// through with one cycle of latency, and each frame's good/bad verdict is driven onto bit 11.
module rx_crc_flag #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   in_c,
  output logic [11:0]   out_c,
  output logic          frame_done,
  output logic [CW-1:0] good_cnt,
  output logic [CW-1:0] bad_cnt
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;
  localparam logic [10:0] L_MIN    = 11'(MIN_LEN);
  localparam logic [10:0] L_MAX    = 11'(MAX_LEN);

  typedef enum logic [1:0] {SKIP, IDLE, FRAME} state_t;

  state_t          r_state;
  logic [31:0]     r_crc;
  logic [10:0]     r_len;
  logic [11:0]     r_out;
  logic            r_done;
  logic [CW-1:0]   r_good_cnt;
  logic [CW-1:0]   r_bad_cnt;

  logic            w_strb;
  logic [31:0]     w_crc_nxt;
  logic [10:0]     w_len_inc;
  logic            w_good;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call, LSB first
  function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    return x;
  endfunction

  assign w_strb    = in_c[9];
  assign w_crc_nxt = f_crc_byte((r_state == IDLE) ? CRC_INIT : r_crc, in_c[7:0]);
  assign w_len_inc = (&r_len) ? r_len : r_len + 11'd1;
  assign w_good    = (r_crc == RESIDUE) && (r_len >= L_MIN) && (r_len <= L_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SKIP;
      r_crc      <= CRC_INIT;
      r_len      <= '0;
      r_out      <= '0;
      r_done     <= 1'b0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_out[10:0] <= in_c[10:0];
      r_done      <= 1'b0;
      // Flag only survives in the gap; any strobe-high cycle clears it
      if (w_strb) r_out[11] <= 1'b0;
      case (r_state)
        SKIP: if (!w_strb) r_state <= IDLE;
        IDLE: if (w_strb) begin
          r_crc   <= w_crc_nxt;
          r_len   <= 11'd1;
          r_state <= FRAME;
        end
        FRAME: if (w_strb) begin
          r_crc <= w_crc_nxt;
          r_len <= w_len_inc;
        end else begin
          r_out[11] <= w_good;
          r_done    <= 1'b1;
          r_state   <= IDLE;
          if (w_good) begin
            if (!(&r_good_cnt)) r_good_cnt <= r_good_cnt + 1'b1;
          end else begin
            if (!(&r_bad_cnt)) r_bad_cnt <= r_bad_cnt + 1'b1;
          end
        end
        default: r_state <= SKIP;
      endcase
    end
  end

  assign out_c      = r_out;
  assign frame_done = r_done;
  assign good_cnt   = r_good_cnt;
  assign bad_cnt    = r_bad_cnt;

endmodule

// File: tb/tb_rx_crc_flag.sv
// Scoreboard bench for rx_crc_flag: frames built with a bench CRC-32 model,
// expected verdicts queued at drive time and popped on frame_done.
module tb_rx_crc_flag;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   in_c;
  logic [11:0]   out_c;
  logic          frame_done;
  logic [CW-1:0] good_cnt, bad_cnt;

  rx_crc_flag #(.MIN_LEN(64), .MAX_LEN(1518), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_c(in_c), .out_c(out_c),
    .frame_done(frame_done), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  bit          exp_q[$];
  logic [7:0]  fb[$];
  logic [11:0] last_in, prev_in;
  logic        exp_flag;
  int          exp_good, exp_bad;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Bit-serial reference: shift register fed MSB-of-reflected-stream style
  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fbk;
    c = 32'hFFFF_FFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        fbk = c[0] ^ q[i][b];
        c   = {1'b0, c[31:1]};
        if (fbk) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  // n total bytes including FCS; flip >= 0 toggles bit 0 of that payload byte
  task automatic build(input int n, input int flip);
    logic [31:0] fcs;
    fb.delete();
    for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom));
    fcs = crc32(fb);
    for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
    if (flip >= 0) fb[flip] = fb[flip] ^ 8'h01;
  endtask

  task automatic step(input bit r, input bit strb, input logic [7:0] d);
    logic [2:0] rb;
    rb   = 3'($urandom);
    rst  = r;
    in_c = {rb[2], rb[1], strb, rb[0], d};
    #1;
    if (r) begin
      chk("rst_out", out_c, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_cnt", {good_cnt, bad_cnt}, 0);
    end
    prev_in = last_in;
    last_in = in_c;
    @(posedge clk); #1;
    if (r) begin
      exp_flag = 1'b0; exp_good = 0; exp_bad = 0;
      exp_q.delete();
      chk("pt_rst", out_c[10:0], 0);
    end else begin
      chk("pt", out_c[10:0], last_in[10:0]);
      if (frame_done) begin
        chk("done_tim", {prev_in[9], last_in[9]}, 2'b10);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_flag = exp_q.pop_front();
          if (exp_flag) exp_good = (exp_good < 15) ? exp_good + 1 : 15;
          else          exp_bad  = (exp_bad  < 15) ? exp_bad  + 1 : 15;
        end
      end else if (last_in[9]) exp_flag = 1'b0;
    end
    chk("flag", out_c[11], exp_flag);
    chk("good_cnt", good_cnt, exp_good);
    chk("bad_cnt", bad_cnt, exp_bad);
  endtask

  task automatic send(input bit expg, input int gap, input int rst_at, input int rst_len);
    bit r;
    if (rst_at < 0) exp_q.push_back(expg);
    foreach (fb[i]) begin
      r = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + rst_len);
      step(r, 1'b1, fb[i]);
    end
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    last_in = '0; prev_in = '0; exp_flag = 1'b0; exp_good = 0; exp_bad = 0;
    rst = 1'b1; in_c = '0;
    #1;
    chk("reset_out", out_c, 0);
    chk("reset_done", frame_done, 0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'($urandom));

    build(64, -1);   send(1'b1, 4, -1, 0);
    chk("t1_good", good_cnt, 1); chk("t1_bad", bad_cnt, 0);
    build(64, 10);   send(1'b0, 4, -1, 0);
    chk("t2_good", good_cnt, 1); chk("t2_bad", bad_cnt, 1);
    build(63, -1);   send(1'b0, 3, -1, 0);
    build(1519, -1); send(1'b0, 3, -1, 0);
    chk("t3_bad", bad_cnt, 3);
    build(64, -1);   send(1'b1, 3, -1, 0);
    build(1518, -1); send(1'b1, 3, -1, 0);
    chk("t3_good", good_cnt, 3);
    build(64, -1);   send(1'b1, 1, -1, 0);
    build(64, -1);   send(1'b1, 3, -1, 0);
    chk("b2b_good", good_cnt, 5);
    fb.delete(); fb.push_back(8'hA5); send(1'b0, 3, -1, 0);
    chk("len1_bad", bad_cnt, 4);

    build(64, -1);   send(1'b0, 3, 30, 5);
    chk("rst_good", good_cnt, 0); chk("rst_bad", bad_cnt, 0);
    build(64, -1);   send(1'b1, 2, -1, 0);
    chk("post_rst_good", good_cnt, 1);

    for (int k = 0; k < 17; k++) begin
      build(64, -1); send(1'b1, 2, -1, 0);
    end
    chk("sat_good", good_cnt, 15);
    chk("sat_bad", bad_cnt, 0);
    chk("q_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
